// File: rtl/powlib_seqchk.sv
// Arithmetic-sequence checker for a FIFO read port: accepts words, counts them, and records mismatches.
// Optional ready throttling via POWLIB_SEQCHK_THROTTLE_EN (16-bit LFSR gates rdrdy about 75% of cycles).
module powlib_seqchk #(
  parameter int W   = 32,
  parameter int INC = 1,
  parameter int CW  = 32,
  parameter int EW  = 16,
  parameter     ID  = "SEQCHK"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [W-1:0]  rddata,
  input  logic          rdvld,
  output logic          rdrdy,
  output logic [CW-1:0] rxcnt,
  output logic [EW-1:0] errcnt,
  output logic          err,
  output logic [W-1:0]  errexp,
  output logic [W-1:0]  errgot,
  output logic          synced
);

  localparam logic [1:0]   ST_IDLE  = 2'd0;
  localparam logic [1:0]   ST_SYNC  = 2'd1;
  localparam logic [1:0]   ST_CHECK = 2'd2;
  localparam logic [W-1:0] INC_W    = W'(INC);

  logic [1:0]    state_q,  state_d;
  logic [W-1:0]  exp_q,    exp_d;
  logic          rdrdy_q,  rdrdy_d;
  logic [CW-1:0] rxcnt_q,  rxcnt_d;
  logic [EW-1:0] errcnt_q, errcnt_d;
  logic          err_q,    err_d;
  logic [W-1:0]  errexp_q, errexp_d;
  logic [W-1:0]  errgot_q, errgot_d;
  logic          synced_q, synced_d;
  logic          xfer_s;
  logic          rdrdy_st_s;
  logic          throttle_ok_s;

  assign xfer_s = rdvld & rdrdy_q;

`ifdef POWLIB_SEQCHK_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, free-running after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign throttle_ok_s = (lfsr_q[1:0] != 2'b00);
`else
  assign throttle_ok_s = 1'b1;
`endif

  // Next-state logic: sequencing, checking, counters; clr overrides any transfer
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    rxcnt_d    = rxcnt_q;
    errcnt_d   = errcnt_q;
    err_d      = err_q;
    errexp_d   = errexp_q;
    errgot_d   = errgot_q;
    rdrdy_st_s = 1'b0;
    case (state_q)
      ST_IDLE:  rdrdy_st_s = 1'b0;
      ST_SYNC:  rdrdy_st_s = en;
      ST_CHECK: rdrdy_st_s = en;
      default:  rdrdy_st_s = 1'b0;
    endcase
    if (clr) begin
      rxcnt_d  = {CW{1'b0}};
      errcnt_d = {EW{1'b0}};
      err_d    = 1'b0;
      errexp_d = {W{1'b0}};
      errgot_d = {W{1'b0}};
      exp_d    = {W{1'b0}};
      if (en) begin
        state_d = ST_SYNC;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (xfer_s && (rxcnt_q != {CW{1'b1}})) begin
        rxcnt_d = rxcnt_q + CW'(1);
      end else begin
        rxcnt_d = rxcnt_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (xfer_s) begin
            exp_d   = rddata + INC_W;
            state_d = ST_CHECK;
          end else if (!en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SYNC;
          end
        end
        // CHECK holds exp across an en pause so resuming causes no false error
        ST_CHECK: begin
          state_d = ST_CHECK;
          if (xfer_s) begin
            if (rddata == exp_q) begin
              exp_d = exp_q + INC_W;
            end else begin
              exp_d    = rddata + INC_W;
              err_d    = 1'b1;
              errexp_d = exp_q;
              errgot_d = rddata;
              if (errcnt_q != {EW{1'b1}}) begin
                errcnt_d = errcnt_q + EW'(1);
              end else begin
                errcnt_d = errcnt_q;
              end
            end
          end else begin
            exp_d = exp_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    rdrdy_d  = rdrdy_st_s & throttle_ok_s;
    synced_d = (state_d == ST_CHECK);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      exp_q    <= {W{1'b0}};
      rdrdy_q  <= 1'b0;
      rxcnt_q  <= {CW{1'b0}};
      errcnt_q <= {EW{1'b0}};
      err_q    <= 1'b0;
      errexp_q <= {W{1'b0}};
      errgot_q <= {W{1'b0}};
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      rdrdy_q  <= rdrdy_d;
      rxcnt_q  <= rxcnt_d;
      errcnt_q <= errcnt_d;
      err_q    <= err_d;
      errexp_q <= errexp_d;
      errgot_q <= errgot_d;
      synced_q <= synced_d;
    end
  end

  assign rdrdy  = rdrdy_q;
  assign rxcnt  = rxcnt_q;
  assign errcnt = errcnt_q;
  assign err    = err_q;
  assign errexp = errexp_q;
  assign errgot = errgot_q;
  assign synced = synced_q;

endmodule

// File: tb/tb_powlib_seqchk.sv
// Directed, table-driven bench for powlib_seqchk (CW=10, EW=2 so both saturation limits are reachable).
module tb_powlib_seqchk;

  localparam int W  = 32;
  localparam int CW = 10;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst, en, clr, rdvld;
  logic [W-1:0]  rddata;
  logic          rdrdy, err, synced;
  logic [CW-1:0] rxcnt;
  logic [EW-1:0] errcnt;
  logic [W-1:0]  errexp, errgot;

  int checks = 0;
  int errors = 0;
  logic low_seen = 1'b0;
  logic [W-1:0] q[$];

  powlib_seqchk #(.W(W), .INC(1), .CW(CW), .EW(EW), .ID("TB")) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .rddata(rddata), .rdvld(rdvld),
    .rdrdy(rdrdy), .rxcnt(rxcnt), .errcnt(errcnt), .err(err),
    .errexp(errexp), .errgot(errgot), .synced(synced)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] d[8];
    int          e_rx;
    int          e_ec;
    logic        e_err;
    logic [31:0] e_exp;
    logic [31:0] e_got;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdrdy"}, 32'(rdrdy), 32'd0);
    chk({tag, "_rxcnt"}, 32'(rxcnt), 32'd0);
    chk({tag, "_errcnt"}, 32'(errcnt), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_errexp"}, errexp, 32'd0);
    chk({tag, "_errgot"}, errgot, 32'd0);
    chk({tag, "_synced"}, 32'(synced), 32'd0);
  endtask

  // Present queued words FIFO-style until npop have transferred or budget expires
  task automatic drain(input int npop, input int budget);
    int popped = 0;
    int cyc = 0;
    logic xf;
    while (popped < npop && q.size() > 0 && cyc < budget) begin
      rdvld = 1'b1;
      rddata = q[0];
      xf = rdrdy;
      if (!rdrdy) low_seen = 1'b1;
      step();
      if (xf) begin
        void'(q.pop_front());
        popped++;
      end
      cyc++;
    end
    rdvld = 1'b0;
    chk("drain_count", 32'(popped), 32'(npop));
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    rdvld = 1'b0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int xfer_while_off;
    logic xf;

    tbl[0] = '{"drop8", 6, '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd0, 32'd0}, 6, 1, 1'b1, 32'd8, 32'd9};
    tbl[1] = '{"wrap", 4, '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'd0, 32'd0, 32'd0, 32'd0}, 4, 0, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{"clean", 4, '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0}, 4, 0, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{"repeat", 3, '{32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 3, 2, 1'b1, 32'd8, 32'd7};
    tbl[4] = '{"twoerr", 5, '{32'd3, 32'd4, 32'd6, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0}, 5, 2, 1'b1, 32'd8, 32'd9};
    tbl[5] = '{"errsat", 5, '{32'd1, 32'd5, 32'd9, 32'd13, 32'd17, 32'd0, 32'd0, 32'd0}, 5, 3, 1'b1, 32'd14, 32'd17};

    rst = 1'b1; en = 1'b0; clr = 1'b0; rdvld = 1'b0; rddata = 32'd0;
    repeat (2) step();
    chk_reset("reset");
    rst = 1'b0;

    en = 1'b1;
    step();
    chk("en_lat1_rdrdy", 32'(rdrdy), 32'd0);
    step();
`ifndef POWLIB_SEQCHK_THROTTLE_EN
    chk("en_lat2_rdrdy", 32'(rdrdy), 32'd1);
`endif
    for (int i = 0; i < 16; i++) q.push_back(32'h10 + 32'(i));
    drain(16, 200);
    chk("base_rxcnt", 32'(rxcnt), 32'd16);
    chk("base_errcnt", 32'(errcnt), 32'd0);
    chk("base_err", 32'(err), 32'd0);
    chk("base_synced", 32'(synced), 32'd1);

    for (int t = 0; t < 6; t++) begin
      clr_pulse();
      chk({tbl[t].name, "_clr_synced"}, 32'(synced), 32'd0);
      q.delete();
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].d[i]);
      drain(tbl[t].n, 100);
      chk({tbl[t].name, "_rxcnt"}, 32'(rxcnt), 32'(tbl[t].e_rx));
      chk({tbl[t].name, "_errcnt"}, 32'(errcnt), 32'(tbl[t].e_ec));
      chk({tbl[t].name, "_err"}, 32'(err), 32'(tbl[t].e_err));
      chk({tbl[t].name, "_errexp"}, errexp, tbl[t].e_exp);
      chk({tbl[t].name, "_errgot"}, errgot, tbl[t].e_got);
    end

    // 100-word stream with a 10-cycle en pause in the middle
    clr_pulse();
    q.delete();
    for (int i = 0; i < 100; i++) q.push_back(32'h1000 + 32'(i));
    drain(50, 400);
    en = 1'b0;
    xfer_while_off = 0;
    for (int c = 0; c < 10; c++) begin
      rdvld = 1'b1;
      rddata = q[0];
      xf = rdrdy;
      step();
      if (xf) begin
        void'(q.pop_front());
        if (c > 0) xfer_while_off++;
      end
      if (c == 0) chk("pause_rdrdy_low", 32'(rdrdy), 32'd0);
    end
    chk("pause_no_xfer", 32'(xfer_while_off), 32'd0);
    chk("pause_synced", 32'(synced), 32'd1);
    en = 1'b1;
    drain(q.size(), 400);
    chk("pause_rxcnt", 32'(rxcnt), 32'd100);
    chk("pause_errcnt", 32'(errcnt), 32'd0);

    // clr coincident with a transfer after three errors
    clr_pulse();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back((i < 3) ? 32'(i + 1) : 32'(2 * i - 1));
    drain(6, 100);
    chk("clrx_pre_errcnt", 32'(errcnt), 32'd3);
    rdvld = 1'b1;
    rddata = 32'd50;
    clr = 1'b1;
    step();
    clr = 1'b0;
    rdvld = 1'b0;
    chk_reset_counters: begin
      chk("clrx_rxcnt", 32'(rxcnt), 32'd0);
      chk("clrx_errcnt", 32'(errcnt), 32'd0);
      chk("clrx_err", 32'(err), 32'd0);
      chk("clrx_errexp", errexp, 32'd0);
      chk("clrx_synced", 32'(synced), 32'd0);
    end
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(32'd60 + 32'(i));
    drain(3, 100);
    chk("clrx_post_rxcnt", 32'(rxcnt), 32'd3);
    chk("clrx_post_errcnt", 32'(errcnt), 32'd0);

    // Long stream: rxcnt saturates at 2^CW-1
    clr_pulse();
    low_seen = 1'b0;
    q.delete();
    for (int i = 0; i < 1030; i++) q.push_back(32'h20000 + 32'(i));
    drain(1030, 5000);
    chk("sat_rxcnt", 32'(rxcnt), 32'd1023);
    chk("sat_errcnt", 32'(errcnt), 32'd0);
`ifdef POWLIB_SEQCHK_THROTTLE_EN
    chk("throttle_low_seen", 32'(low_seen), 32'd1);
`endif

    // Synchronous reset mid-stream beats a concurrent transfer
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(32'h500 + 32'(i));
    drain(2, 100);
    rdvld = 1'b1;
    rddata = 32'h777;
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    rdvld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
